// File: rtl/pipelinedefs.sv
// Shared definitions for the memory-stage data cache: CPU bus field positions and FSM states.
package pipelinedefs;

   localparam int unsigned DC_REQ_W    = 66;
   localparam int unsigned DC_RSP_W    = 33;
   localparam int unsigned DC_EN       = 65;
   localparam int unsigned DC_WE       = 64;
   localparam int unsigned DC_ADDR_HI  = 63;
   localparam int unsigned DC_ADDR_LO  = 32;
   localparam int unsigned DC_WDATA_HI = 31;
   localparam int unsigned DC_WDATA_LO = 0;
   localparam int unsigned DC_MISS     = 32;
   localparam int unsigned DC_RDATA_HI = 31;
   localparam int unsigned DC_RDATA_LO = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } dc_state_e;

endpackage

// File: rtl/dcache_wbuf.sv
// Single-entry write buffer: holds one store (word address + data) until memory acks its drain.
module dcache_wbuf #(
   parameter int unsigned AW = 30,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          drain,
   input  logic [AW-1:0] push_addr,
   input  logic [DW-1:0] push_data,
   output logic          full,
   output logic          full_nxt_c,
   output logic [AW-1:0] addr_nxt_c,
   output logic [DW-1:0] data_nxt_c
);

   logic          full_q, full_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;

   // Push is only issued while empty, so it never collides with a drain.
   always_comb begin
      full_d = full_q;
      addr_d = addr_q;
      data_d = data_q;
      if (drain) begin
         full_d = 1'b0;
      end
      if (push) begin
         full_d = 1'b1;
         addr_d = push_addr;
         data_d = push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign full       = full_q;
   assign full_nxt_c = full_d;
   assign addr_nxt_c = addr_d;
   assign data_nxt_c = data_d;

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with line-burst refill
// and a single-entry write buffer in front of a word-wide memory port.
module dcache_ctrl
   import pipelinedefs::*;
#(
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic [DC_REQ_W-1:0] Dcache_bus_out,
   output logic [DC_RSP_W-1:0] Dcache_bus_in,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [31:0]         mem_wdata,
   input  logic                mem_ack,
   input  logic [31:0]         mem_rdata
);

   localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);
   localparam int unsigned WA_W     = ADDR_W - 2;
   localparam int unsigned LINE_W   = WA_W - OFF_BITS;
   localparam int unsigned TAG_BITS = LINE_W - INDEX_BITS;
   localparam int unsigned LINES    = 2 ** INDEX_BITS;
   localparam int unsigned DW       = DC_WDATA_HI - DC_WDATA_LO + 1;
   localparam int unsigned AI_W     = INDEX_BITS + OFF_BITS;
   localparam logic [OFF_BITS-1:0] CNT_LAST = OFF_BITS'(LINE_WORDS - 1);

   logic                  req_en, req_we;
   logic [WA_W-1:0]       req_waddr;
   logic [DW-1:0]         req_wdata;
   logic [OFF_BITS-1:0]   req_off;
   logic [INDEX_BITS-1:0] req_idx;
   logic [TAG_BITS-1:0]   req_tag;
   logic                  unused_addr_lsb;

   logic [DW-1:0]         data_mem [LINES*LINE_WORDS];
   logic [TAG_BITS-1:0]   tag_mem  [LINES];

   dc_state_e             state_q, state_d;
   logic [OFF_BITS-1:0]   cnt_q, cnt_d;
   logic [LINE_W-1:0]     line_q, line_d;
   logic [LINES-1:0]      valid_q, valid_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;

   logic [INDEX_BITS-1:0] line_idx;
   logic [TAG_BITS-1:0]   line_tag;
   logic                  hit_c, miss_c;
   logic [DW-1:0]         rdata_c;
   logic                  ack_v, fill_ack;
   logic                  arr_we, tag_we;
   logic [AI_W-1:0]       arr_waddr;
   logic [DW-1:0]         arr_wdata;
   logic                  wb_push, wb_drain, wb_full, wb_full_nxt;
   logic [WA_W-1:0]       wb_addr_nxt;
   logic [DW-1:0]         wb_data_nxt;

   // Request decode; the byte offset within a word is not used.
   assign req_en          = Dcache_bus_out[DC_EN];
   assign req_we          = Dcache_bus_out[DC_WE];
   assign req_waddr       = Dcache_bus_out[DC_ADDR_LO+2 +: WA_W];
   assign req_wdata       = Dcache_bus_out[DC_WDATA_HI:DC_WDATA_LO];
   assign unused_addr_lsb = ^Dcache_bus_out[DC_ADDR_LO +: 2];
   assign req_off         = req_waddr[OFF_BITS-1:0];
   assign req_idx         = req_waddr[OFF_BITS +: INDEX_BITS];
   assign req_tag         = req_waddr[WA_W-1 -: TAG_BITS];

   assign line_idx = line_q[INDEX_BITS-1:0];
   assign line_tag = line_q[LINE_W-1 -: TAG_BITS];

   assign hit_c   = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign miss_c  = req_en && ((state_q != ST_IDLE) || (!req_we && !hit_c) || (req_we && wb_full));
   assign rdata_c = (req_en && !req_we && hit_c && (state_q == ST_IDLE)) ? data_mem[{req_idx, req_off}] : '0;

   assign Dcache_bus_in[DC_MISS]                 = miss_c;
   assign Dcache_bus_in[DC_RDATA_HI:DC_RDATA_LO] = rdata_c;

   assign ack_v    = mem_ack && mem_req_q;
   assign wb_drain = ack_v && mem_we_q;
   assign fill_ack = ack_v && !mem_we_q;

   dcache_wbuf #(
      .AW (WA_W),
      .DW (DW)
   ) u_wbuf (
      .clk        (Clk),
      .rst        (Rst),
      .push       (wb_push),
      .drain      (wb_drain),
      .push_addr  (req_waddr),
      .push_data  (req_wdata),
      .full       (wb_full),
      .full_nxt_c (wb_full_nxt),
      .addr_nxt_c (wb_addr_nxt),
      .data_nxt_c (wb_data_nxt)
   );

   // Next-state, array write enables and next memory-port values.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      line_d      = line_q;
      valid_d     = valid_q;
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      arr_we      = 1'b0;
      arr_waddr   = {req_idx, req_off};
      arr_wdata   = req_wdata;
      tag_we      = 1'b0;
      wb_push     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_en) begin
               if (req_we) begin
                  if (!wb_full) begin
                     wb_push = 1'b1;
                     arr_we  = hit_c;
                  end
               end else if (!hit_c && !wb_full) begin
                  // A pending write drains first so the refill sees it.
                  state_d          = ST_FILL;
                  cnt_d            = '0;
                  line_d           = {req_tag, req_idx};
                  valid_d[req_idx] = 1'b0;
               end
            end
         end
         ST_FILL: begin
            if (fill_ack) begin
               arr_we    = 1'b1;
               arr_waddr = {line_idx, cnt_q};
               arr_wdata = mem_rdata;
               cnt_d     = cnt_q + OFF_BITS'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d           = ST_DONE;
                  tag_we            = 1'b1;
                  valid_d[line_idx] = 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_FILL) begin
         mem_req_d  = 1'b1;
         mem_we_d   = 1'b0;
         mem_addr_d = {line_d, cnt_d, 2'b00};
      end else if ((state_d == ST_IDLE) && wb_full_nxt) begin
         mem_req_d   = 1'b1;
         mem_we_d    = 1'b1;
         mem_addr_d  = {wb_addr_nxt, 2'b00};
         mem_wdata_d = wb_data_nxt;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         line_q      <= '0;
         valid_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         line_q      <= line_d;
         valid_q     <= valid_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Data and tag storage need no reset; valid bits gate every use.
   always_ff @(posedge Clk) begin
      if (arr_we) begin
         data_mem[arr_waddr] <= arr_wdata;
      end
      if (tag_we) begin
         tag_mem[line_idx] <= line_tag;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed CPU ops push expected responses and memory
// transactions; a CPU monitor and a memory responder pop and compare them.
module tb_dcache_ctrl;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_txn_t;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        bus_en, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [65:0] Dcache_bus_out;
   logic [32:0] Dcache_bus_in;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   int n_acks = 0;
   int ack_delay = 0;
   int wait_cnt = 0;

   logic [31:0] exp_cpu [$];
   mem_txn_t    exp_mem [$];
   logic [31:0] mem_model [bit [31:0]];

   assign Dcache_bus_out = {bus_en, bus_we, bus_addr, bus_wdata};

   dcache_ctrl dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .Dcache_bus_out (Dcache_bus_out),
      .Dcache_bus_in  (Dcache_bus_in),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic push_rd_line(input logic [31:0] base);
      for (int i = 0; i < 4; i++) begin
         exp_mem.push_back({1'b0, base + 32'(4 * i), 32'h0});
      end
   endtask

   task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
      exp_mem.push_back({1'b1, addr, data});
   endtask

   // Called just after a rising edge; returns on the edge that accepts the op.
   task automatic cpu_op(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data,
                         input logic exp_miss0, input int exp_stall);
      int stall;
      bit done;
      stall = 0;
      done  = 1'b0;
      exp_cpu.push_back(exp_data);
      #2;
      bus_en = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
      for (int i = 0; i < 200 && !done; i++) begin
         #1;
         if (i == 0) chk({name, "_miss0"}, 64'(Dcache_bus_in[32]), 64'(exp_miss0));
         if (!Dcache_bus_in[32]) begin
            done = 1'b1;
         end else begin
            stall++;
            @(posedge Clk);
            #2;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got stalled required accept", name);
         void'(exp_cpu.pop_back());
         bus_en = 1'b0;
      end else begin
         chk({name, "_stall"}, 64'(stall), 64'(exp_stall));
      end
      @(posedge Clk);
   endtask

   task automatic idle(input int n);
      #2;
      bus_en = 1'b0;
      #1;
      chk("idle_rsp", 64'(Dcache_bus_in), 64'h0);
      repeat (n) @(posedge Clk);
   endtask

   // CPU monitor: every accepted request returns its expected data word.
   initial begin
      logic [31:0] e;
      forever begin
         @(posedge Clk);
         #4;
         if (!Rst && bus_en && !Dcache_bus_in[32]) begin
            if (exp_cpu.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL cpu_unexpected: got accept at %0h required none", bus_addr);
            end else begin
               e = exp_cpu.pop_front();
               chk("cpu_rdata", 64'(Dcache_bus_in[31:0]), 64'(e));
            end
         end
      end
   end

   // Memory responder and monitor: acks after ack_delay waiting cycles, checks each txn.
   initial begin
      mem_txn_t t;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge Clk);
         #1;
         if (mem_ack) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
         end else if (mem_req && !Rst) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack = 1'b1;
               n_acks++;
               if (exp_mem.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL mem_unexpected: got we=%0d addr=%0h required none", mem_we, mem_addr);
               end else begin
                  t = exp_mem.pop_front();
                  chk("mem_we", 64'(mem_we), 64'(t.we));
                  chk("mem_addr", 64'(mem_addr), 64'(t.addr));
                  if (t.we) chk("mem_wdata", 64'(mem_wdata), 64'(t.wdata));
               end
               if (mem_we) mem_model[mem_addr] = mem_wdata;
               else        mem_rdata = mem_model[mem_addr];
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish");
      $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
      $fatal(1);
   end

   initial begin
      int base;
      bit got2;
      Rst = 1'b1;
      bus_en = 1'b0; bus_we = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
      mem_model[32'h100]  = 32'hA000_0100;
      mem_model[32'h104]  = 32'hB000_0104;
      mem_model[32'h108]  = 32'hC000_0108;
      mem_model[32'h10C]  = 32'hD000_010C;
      mem_model[32'h1100] = 32'hE000_1100;
      mem_model[32'h1104] = 32'hE000_1104;
      mem_model[32'h1108] = 32'hE000_1108;
      mem_model[32'h110C] = 32'hE000_110C;
      mem_model[32'h2000] = 32'h0F00_2000;
      mem_model[32'h2004] = 32'h0F00_2004;
      mem_model[32'h2008] = 32'h0F00_2008;
      mem_model[32'h200C] = 32'h0F00_200C;

      repeat (2) @(posedge Clk);
      #2;
      chk("rst_rsp", 64'(Dcache_bus_in), 64'h0);
      chk("rst_req", 64'(mem_req), 64'h0);
      chk("rst_we", 64'(mem_we), 64'h0);
      chk("rst_addr", 64'(mem_addr), 64'h0);
      chk("rst_wdata", 64'(mem_wdata), 64'h0);
      Rst = 1'b0;
      @(posedge Clk);

      // Reset while the fill has completed two of its four words.
      ack_delay = 2;
      push_rd_line(32'h100);
      void'(exp_mem.pop_back());
      void'(exp_mem.pop_back());
      base = n_acks;
      got2 = 1'b0;
      #2;
      bus_en = 1'b1; bus_we = 1'b0; bus_addr = 32'h104;
      for (int i = 0; i < 100 && !got2; i++) begin
         @(posedge Clk);
         #2;
         if (n_acks - base >= 2) got2 = 1'b1;
      end
      chk("rst_fill_acks", 64'(n_acks - base), 64'd2);
      @(posedge Clk);
      #2;
      Rst = 1'b1;
      #1;
      chk("rst_fill_req", 64'(mem_req), 64'h0);
      chk("rst_fill_rsp", 64'(Dcache_bus_in), 64'h1_0000_0000);
      chk("rst_fill_memq", 64'(exp_mem.size()), 64'h0);
      @(posedge Clk);
      #2;
      Rst = 1'b0;
      bus_en = 1'b0;
      @(posedge Clk);

      // Cold load of 0x104 refills the line again and returns B.
      ack_delay = 0;
      push_rd_line(32'h100);
      cpu_op("cold_ld", 1'b0, 32'h104, 32'h0, 32'hB000_0104, 1'b1, 9);

      // Store hit with empty buffer, then load back the new word.
      push_wr(32'h104, 32'hDEAD_BEEF);
      cpu_op("st_hit", 1'b1, 32'h104, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
      cpu_op("ld_after_st", 1'b0, 32'h104, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
      idle(5);

      // Back-to-back stores with slow acks: second waits for the first drain.
      ack_delay = 3;
      push_wr(32'h108, 32'h1234_5678);
      push_wr(32'h10C, 32'h9ABC_DEF0);
      cpu_op("st_b2b_1", 1'b1, 32'h108, 32'h1234_5678, 32'h0, 1'b0, 0);
      cpu_op("st_b2b_2", 1'b1, 32'h10C, 32'h9ABC_DEF0, 32'h0, 1'b1, 4);
      cpu_op("ld_b2b_1", 1'b0, 32'h108, 32'h0, 32'h1234_5678, 1'b0, 0);
      cpu_op("ld_b2b_2", 1'b0, 32'h10C, 32'h0, 32'h9ABC_DEF0, 1'b0, 0);
      idle(12);

      // Store miss then load: load waits for the drain, then refills with the stored word.
      ack_delay = 1;
      push_wr(32'h2000, 32'h5A5A_A5A5);
      push_rd_line(32'h2000);
      cpu_op("st_miss", 1'b1, 32'h2000, 32'h5A5A_A5A5, 32'h0, 1'b0, 0);
      cpu_op("ld_raw", 1'b0, 32'h2000, 32'h0, 32'h5A5A_A5A5, 1'b1, 15);
      cpu_op("ld_raw_w1", 1'b0, 32'h2004, 32'h0, 32'h0F00_2004, 1'b0, 0);
      idle(5);

      // Conflict on index 0x10: 0x1100 evicts 0x100, which then refills.
      ack_delay = 0;
      cpu_op("cf_ld_100", 1'b0, 32'h100, 32'h0, 32'hA000_0100, 1'b0, 0);
      push_rd_line(32'h1100);
      cpu_op("cf_ld_1100", 1'b0, 32'h1100, 32'h0, 32'hE000_1100, 1'b1, 9);
      push_rd_line(32'h100);
      cpu_op("cf_reld_100", 1'b0, 32'h100, 32'h0, 32'hA000_0100, 1'b1, 9);
      cpu_op("cf_ld_104", 1'b0, 32'h104, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
      cpu_op("cf_ld_10c", 1'b0, 32'h10C, 32'h0, 32'h9ABC_DEF0, 1'b0, 0);
      idle(5);

      chk("end_cpu_q", 64'(exp_cpu.size()), 64'h0);
      chk("end_mem_q", 64'(exp_mem.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
